sha256_padder: RTL and testbench
================================

# sha256_padder

Message pre-processing stage that sits directly upstream of `sha256_core`. It accepts a byte-granular message as a stream of big-endian 32-bit words and packs them into 512-bit blocks. It applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit message bit-length. Blocks are presented one at a time on a valid/ready interface, with a last-block flag that the core controller uses to terminate the hash.

## Interface
Parameters:
- `BlockWidth`, 512, output block width; only 512 is supported.
- `LenWidth`, 64, width of the appended bit-length field; only 64 is supported.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clear_i`  in  1  synchronous abort; discards the partial block and the length count.
- `data_i`  in  32  message word; byte 0 is in `[31:24]`.
- `data_valid_i`  in  1  `data_i` is valid.
- `data_last_i`  in  1  this word ends the message.
- `data_bytes_i`  in  3  valid bytes in a last word, range 1..4. Value 0 means an empty message and `data_i` is ignored. Values 5..7 are treated as 4. Ignored when `data_last_i`=0.
- `data_ready_o`  out  1  padder accepts a word this cycle.
- `block_o`  out  BlockWidth  assembled block; word 0 is in `[511:480]`.
- `block_valid_o`  out  1  `block_o` is valid.
- `block_last_o`  out  1  block carries the length field (final block of the message).
- `block_ready_i`  in  1  downstream consumes the block.
- `busy_o`  out  1  high when not in COLLECT or when the word index is nonzero.

## Operation
- Registers:
  - 16x32 buffer
  - 4-bit word index `idx`
  - 64-bit bit counter `len`
  - flags `need80` and `lenfits`
  - state
- State COLLECT (`data_ready_o`=1). On each word transfer:
  - Not last: `buf[idx]=data_i`, `len+=32`, `idx++`. If `idx` was 15, go to EMIT with `block_last_o`=0, then return to COLLECT.
  - Last, bytes n in 1..3: keep the upper n bytes, put 0x80 in byte n, zero the rest. Set `len+=8n` and `lenfits=(idx<=13)`, then `idx++` and go to PAD. The `lenfits` compare uses the index the 0x80 byte was written to, i.e. `idx` before the increment.
  - Last, n=4: store the word, `len+=32`, `idx++`, `need80=1`, go to PAD. If `idx` was 15, first go to EMIT (not last) with `need80` held, then continue in PAD.
  - Last, n=0: `need80=1`, go to PAD without writing.
- State PAD (`data_ready_o`=0). Writes exactly one word per cycle:
  - If `need80`: `buf[idx]=0x80000000`, `lenfits=(idx<=13)`, clear `need80`.
  - Else if !`lenfits`: write zero.
  - Else: write zero for `idx<14`, `len[63:32]` at `idx`=14, `len[31:0]` at `idx`=15.
  - After every write, `idx++`. A write at `idx`=15 goes to EMIT, with `block_last_o`=`lenfits` and `need80`=0 at the time of that write.
  - After a non-last EMIT from PAD, return to PAD with `idx`=0 and `lenfits` forced to 1.
- State EMIT: `block_valid_o`=1 and `block_o` = buffer. On `block_ready_i`:
  - Clear `idx`.
  - If `block_last_o`: clear `len` and the flags, go to COLLECT.
  - Otherwise resume COLLECT or PAD as recorded.
- `len` wraps modulo 2^64.
- `clear_i` takes precedence over all transfers in its cycle. Next cycle the padder is in reset state. It may withdraw `block_valid_o`; this is the only allowed withdrawal.

## Timing
- Reset values:
  - `data_ready_o`=1 (COLLECT)
  - `block_valid_o`=0
  - `block_last_o`=0
  - `block_o`=0
  - `busy_o`=0
  - internal `len`=0, `idx`=0
- An assertion of `rst_i` mid-message drops all state immediately.
- Accept throughput is one word per cycle in COLLECT.
- The transition into EMIT is registered. `block_valid_o` rises the cycle after the 16th word is written.
- Once asserted, `block_valid_o`, `block_o` and `block_last_o` hold stable until `block_ready_i`. The transfer happens on the edge where valid&ready are both high.
- Padding latency, counted in cycles from the last-word transfer to `block_valid_o`, equals the number of PAD words written.
  - Example: last word at `idx`=13 with n=4 gives 2 pad words (0x80 word, then a zero word at `idx`=15). The first block is emitted, then 16 pad cycles follow for the length block.
- `data_ready_o` is low throughout PAD and EMIT. No input is accepted before the final block transfers.

## Test plan
- "abc" as one last word 0x61626300, n=3 -> one block: word0=0x61626380, words1-14=0, word15=0x00000018, `block_last_o`=1.
- Empty message (last, n=0) -> word0=0x80000000, all other words 0, `block_last_o`=1.
- 55 bytes (13 full words + last n=3) -> one block: word13 = last 3 bytes followed by 0x80, length field 0x1B8, `block_last_o`=1.
- 56 bytes (14 words, last n=4) -> first block: word14=0x80000000, word15=0, `block_last_o`=0. Second block: words0-13=0, word15=0x1C0, `block_last_o`=1.
- 64 bytes with `block_ready_i` held low for 10 cycles after each valid -> `block_o` stable throughout and `data_ready_o`=0. Second block is 0x80000000, zeros, length 0x200.
- `rst_i` pulsed after 7 words, then "abc" sent -> the output equals the "abc" test vector (no stale length). The same result is required when using `clear_i` instead of `rst_i`.

Source files
------------

// File: rtl/sha256_padder_if.sv
// Stream interface between a message source, the SHA-256 padder and the
// block consumer. Signal names keep the padder's port view (_i into the
// padder, _o out of it) so waveforms read the same on both sides.
interface sha256_padder_if #(
  parameter int BlockWidth = 512
);
  logic [31:0]           data_i;
  logic                  data_valid_i;
  logic                  data_last_i;
  logic [2:0]            data_bytes_i;
  logic                  data_ready_o;
  logic [BlockWidth-1:0] block_o;
  logic                  block_valid_o;
  logic                  block_last_o;
  logic                  block_ready_i;
  logic                  busy_o;

  // Padder side.
  modport slave (
    input  data_i, data_valid_i, data_last_i, data_bytes_i, block_ready_i,
    output data_ready_o, block_o, block_valid_o, block_last_o, busy_o
  );

  // Environment side: message source plus block consumer.
  modport master (
    output data_i, data_valid_i, data_last_i, data_bytes_i, block_ready_i,
    input  data_ready_o, block_o, block_valid_o, block_last_o, busy_o
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit message words into
// 512-bit blocks, appends the 0x80 marker, zero fill and the 64-bit
// message bit length, and hands blocks downstream on a valid/ready pair.
// Only BlockWidth=512 and LenWidth=64 are meaningful.
module sha256_padder #(
  parameter int BlockWidth = 512,
  parameter int LenWidth   = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  sha256_padder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PAD     = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  resume_pad_q, resume_pad_d; // EMIT returns to PAD
  logic                  last_q, last_d;             // block being emitted is final
  logic [3:0]            idx_q, idx_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic                  need80_q, need80_d;
  logic                  lenfits_q, lenfits_d;

  logic [31:0]           buf_q [16];
  logic                  wr_en;
  logic [31:0]           wr_word;

  logic                  accept;
  logic [2:0]            n_eff;
  logic [BlockWidth-1:0] flat_blk;

  // Keep the upper n bytes of the final word, mark the end with 0x80 and
  // zero whatever follows.
  function automatic logic [31:0] pad_word(input logic [31:0] d,
                                           input logic [2:0]  n);
    case (n)
      3'd1:    return {d[31:24], 8'h80, 16'h0000};
      3'd2:    return {d[31:16], 8'h80, 8'h00};
      default: return {d[31:8],  8'h80};
    endcase
  endfunction

  assign accept = bus.data_valid_i && (state_q == ST_COLLECT);
  // Byte counts 5..7 behave as a full word.
  assign n_eff  = (bus.data_bytes_i > 3'd4) ? 3'd4 : bus.data_bytes_i;

  // Next-state, buffer write and bookkeeping for the padding FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    resume_pad_d = resume_pad_q;
    last_d       = last_q;
    idx_d        = idx_q;
    len_d        = len_q;
    need80_d     = need80_q;
    lenfits_d    = lenfits_q;
    wr_en        = 1'b0;
    wr_word      = 32'h0;

    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (!bus.data_last_i) begin
            wr_en   = 1'b1;
            wr_word = bus.data_i;
            len_d   = len_q + LenWidth'(32);
            idx_d   = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d      = ST_EMIT;
              last_d       = 1'b0;
              resume_pad_d = 1'b0;
            end
          end else if (n_eff == 3'd0) begin
            // Empty tail: nothing stored, the marker goes in from PAD.
            need80_d = 1'b1;
            state_d  = ST_PAD;
          end else if (n_eff == 3'd4) begin
            wr_en    = 1'b1;
            wr_word  = bus.data_i;
            len_d    = len_q + LenWidth'(32);
            idx_d    = idx_q + 4'd1;
            need80_d = 1'b1;
            if (idx_q == 4'd15) begin
              state_d      = ST_EMIT;
              last_d       = 1'b0;
              resume_pad_d = 1'b1;
            end else begin
              state_d = ST_PAD;
            end
          end else begin
            wr_en     = 1'b1;
            wr_word   = pad_word(bus.data_i, n_eff);
            len_d     = len_q + LenWidth'({n_eff, 3'b000});
            lenfits_d = (idx_q <= 4'd13);
            idx_d     = idx_q + 4'd1;
            // Marker landed in the last slot: the block is full, so emit it
            // and build the length block afterwards.
            if (idx_q == 4'd15) begin
              state_d      = ST_EMIT;
              last_d       = 1'b0;
              resume_pad_d = 1'b1;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        wr_en = 1'b1;
        if (need80_q) begin
          wr_word   = 32'h8000_0000;
          lenfits_d = (idx_q <= 4'd13);
          need80_d  = 1'b0;
        end else if (!lenfits_q) begin
          wr_word = 32'h0;
        end else if (idx_q == 4'd14) begin
          wr_word = len_q[63:32];
        end else if (idx_q == 4'd15) begin
          wr_word = len_q[31:0];
        end else begin
          wr_word = 32'h0;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d      = ST_EMIT;
          last_d       = !need80_q && lenfits_q;
          resume_pad_d = 1'b1;
        end
      end

      ST_EMIT: begin
        if (bus.block_ready_i) begin
          idx_d = 4'd0;
          if (last_q) begin
            len_d     = '0;
            need80_d  = 1'b0;
            lenfits_d = 1'b0;
            last_d    = 1'b0;
            state_d   = ST_COLLECT;
          end else if (resume_pad_q) begin
            // The next block is a pure padding block, so the length fits.
            lenfits_d = 1'b1;
            state_d   = ST_PAD;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    // Abort wins over any transfer in the same cycle.
    if (clear_i) begin
      state_d      = ST_COLLECT;
      resume_pad_d = 1'b0;
      last_d       = 1'b0;
      idx_d        = 4'd0;
      len_d        = '0;
      need80_d     = 1'b0;
      lenfits_d    = 1'b0;
      wr_en        = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q      <= ST_COLLECT;
      resume_pad_q <= 1'b0;
      last_q       <= 1'b0;
      idx_q        <= 4'd0;
      len_q        <= '0;
      need80_q     <= 1'b0;
      lenfits_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_pad_q <= resume_pad_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      need80_q     <= need80_d;
      lenfits_q    <= lenfits_d;
    end
  end

  // Block buffer, one word written per cycle at the current index.
  always_ff @(posedge clk_i) begin
    // NOTE: the buffer has no reset; every slot is rewritten before a block
    // is emitted and block_o is gated to zero outside EMIT.
    if (wr_en) begin
      buf_q[idx_q] <= wr_word;
    end
  end

  // Flatten the buffer with word 0 in the most significant position.
  always_comb begin
    flat_blk = '0;
    for (int i = 0; i < 16; i++) begin
      flat_blk[BlockWidth-1-32*i -: 32] = buf_q[i];
    end
  end

  assign bus.data_ready_o  = (state_q == ST_COLLECT);
  assign bus.block_valid_o = (state_q == ST_EMIT);
  assign bus.block_last_o  = (state_q == ST_EMIT) && last_q;
  assign bus.block_o       = (state_q == ST_EMIT) ? flat_blk : '0;
  assign bus.busy_o        = (state_q != ST_COLLECT) || (idx_q != 4'd0);

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: a byte-level padding model feeds
// a scoreboard queue of expected blocks, a monitor pops and compares
// each transferred block, and hand-written sequences cover abort cases.
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  sha256_padder_if u_if ();

  sha256_padder dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .bus     (u_if.slave)
  );

  typedef struct {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  typedef struct {
    int         nbytes;
    int         seed;
    logic [2:0] full_code;  // byte count driven for a full last word
    bit         stall;
    int         exp_blocks;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   blocks_seen = 0;
  bit   stall_en = 1'b0;
  int   stall_cnt = 0;

  logic [511:0] held_blk;
  logic         held_last;
  bit           pending = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] byte_at(input int seed, input int i);
    return 8'(seed + i * 37 + (i >> 3));
  endfunction

  // Consumer: ready high, or held low for 10 cycles of each valid.
  always @(posedge clk) begin
    #1;
    if (u_if.block_valid_o) stall_cnt++;
    else stall_cnt = 0;
    u_if.block_ready_i = !stall_en || (stall_cnt > 10);
  end

  // Monitor: transfers happen on the posedge after a negedge that sees
  // valid and ready both high.
  always @(negedge clk) begin
    if (u_if.block_valid_o) begin
      check(u_if.data_ready_o === 1'b0, "ready_low_in_emit",
            512'(u_if.data_ready_o), 512'd0);
      if (pending) begin
        check(u_if.block_o === held_blk, "block_stable", u_if.block_o, held_blk);
        check(u_if.block_last_o === held_last, "last_stable",
              512'(u_if.block_last_o), 512'(held_last));
      end
      if (u_if.block_ready_i) begin
        blocks_seen++;
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_block", u_if.block_o, 512'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(u_if.block_o === e.blk, "block_data", u_if.block_o, e.blk);
          check(u_if.block_last_o === e.last, "block_last",
                512'(u_if.block_last_o), 512'(e.last));
        end
      end else begin
        pending   = 1'b1;
        held_blk  = u_if.block_o;
        held_last = u_if.block_last_o;
      end
    end else begin
      pending = 1'b0;
    end
  end

  // Reference padding: message bytes, 0x80, zeros, 64-bit bit length.
  task automatic model(input int n, input int seed);
    logic [7:0]  b[$];
    logic [63:0] bits;
    int          total;
    total = ((n + 9 + 63) / 64) * 64;
    for (int i = 0; i < n; i++) b.push_back(byte_at(seed, i));
    b.push_back(8'h80);
    while (b.size() < total - 8) b.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
    for (int blk = 0; blk < total / 64; blk++) begin
      exp_t e;
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = b[64*blk + j];
      e.last = (blk == total / 64 - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer.
  task automatic send_word(input logic [31:0] d, input bit last,
                           input logic [2:0] nb);
    int t = 0;
    u_if.data_i       = d;
    u_if.data_last_i  = last;
    u_if.data_bytes_i = nb;
    u_if.data_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (u_if.data_ready_o) break;
      t++;
      if (t > 300) begin
        check(1'b0, "send_timeout", 512'(u_if.data_ready_o), 512'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
    u_if.data_bytes_i = 3'd0;
    u_if.data_i       = 32'h0;
  endtask

  // Drive n message bytes; garbage fills unused byte lanes and fields.
  task automatic send_msg(input int n, input int seed, input logic [2:0] full_code,
                          input int words_only);
    int nw;
    @(posedge clk);
    #1;
    if (n == 0) begin
      send_word($urandom, 1'b1, 3'd0);
    end else begin
      nw = (n + 3) / 4;
      if (words_only > 0) nw = words_only;
      for (int w = 0; w < nw; w++) begin
        logic [31:0] d;
        int          rem;
        bit          last;
        rem  = n - 4 * w;
        last = (words_only == 0) && (w == nw - 1);
        d    = $urandom;
        for (int k = 0; k < 4; k++) begin
          if (k < rem) d[31-8*k -: 8] = byte_at(seed, 4 * w + k);
        end
        if (last) send_word(d, 1'b1, (rem >= 4) ? full_code : 3'(rem));
        else      send_word(d, 1'b0, 3'($urandom_range(0, 7)));
      end
    end
    idle_inputs();
  endtask

  task automatic drain(input int exp_blocks, input string name);
    int t = 0;
    while ((exp_q.size() != 0 || u_if.busy_o) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(t < 2000, "drain_timeout", 512'(t), 512'd2000);
    check(blocks_seen == exp_blocks, name, 512'(blocks_seen), 512'(exp_blocks));
    check(u_if.data_ready_o === 1'b1, "ready_after_msg",
          512'(u_if.data_ready_o), 512'd1);
    exp_q.delete();
    blocks_seen = 0;
  endtask

  task automatic check_idle(input string name);
    check(u_if.data_ready_o === 1'b1, {name, "_ready"}, 512'(u_if.data_ready_o), 512'd1);
    check(u_if.block_valid_o === 1'b0, {name, "_valid"}, 512'(u_if.block_valid_o), 512'd0);
    check(u_if.block_last_o === 1'b0, {name, "_last"}, 512'(u_if.block_last_o), 512'd0);
    check(u_if.block_o === 512'd0, {name, "_block"}, u_if.block_o, 512'd0);
    check(u_if.busy_o === 1'b0, {name, "_busy"}, 512'(u_if.busy_o), 512'd0);
  endtask

  task automatic abc_vector();
    exp_t e;
    e.blk  = {32'h6162_6380, 448'd0, 32'h0000_0018};
    e.last = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    send_word(32'h6162_63a5, 1'b1, 3'd3);
    idle_inputs();
    drain(1, "abc_blocks");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    vecs = '{
      '{0,   1,  3'd4, 1'b0, 1},
      '{3,   2,  3'd4, 1'b0, 1},
      '{52,  3,  3'd4, 1'b0, 1},
      '{53,  4,  3'd4, 1'b0, 1},
      '{55,  5,  3'd4, 1'b0, 1},
      '{56,  6,  3'd4, 1'b0, 2},
      '{57,  7,  3'd4, 1'b0, 2},
      '{60,  8,  3'd7, 1'b0, 2},
      '{63,  9,  3'd4, 1'b0, 2},
      '{64, 10,  3'd4, 1'b1, 2},
      '{119, 11, 3'd4, 1'b0, 2},
      '{120, 12, 3'd5, 1'b0, 3},
      '{200, 13, 3'd4, 1'b1, 4}
    };

    idle_inputs();
    #3;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Hand vectors: "abc" and the empty message with literal expectations.
    abc_vector();
    begin
      exp_t e;
      e.blk  = {32'h8000_0000, 480'd0};
      e.last = 1'b1;
      exp_q.push_back(e);
      send_msg(0, 0, 3'd4, 0);
      drain(1, "empty_blocks");
    end

    // Table-driven messages against the byte-level model.
    for (int v = 0; v < 13; v++) begin
      stall_en = vecs[v].stall;
      model(vecs[v].nbytes, vecs[v].seed);
      send_msg(vecs[v].nbytes, vecs[v].seed, vecs[v].full_code, 0);
      drain(vecs[v].exp_blocks, $sformatf("blocks_%0d_bytes", vecs[v].nbytes));
    end
    stall_en = 1'b0;

    // Reset mid-message drops the partial block and length.
    send_msg(28, 20, 3'd4, 7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    abc_vector();

    // Synchronous clear mid-message behaves the same.
    send_msg(28, 21, 3'd4, 7);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_idle("clear_mid");
    abc_vector();

    // Clear while a block is held pending withdraws it.
    stall_en = 1'b1;
    send_msg(64, 22, 3'd4, 0);
    begin
      int t = 0;
      while (!u_if.block_valid_o && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check(t < 100, "clear_emit_wait", 512'(t), 512'd100);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    stall_en = 1'b0;
    check_idle("clear_emit");
    blocks_seen = 0;
    abc_vector();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
